// File: rtl/my_mult_axil_slave_if.sv
// AXI4-Lite register-bus bundle for the multiplier endpoint.
// Signal names follow the AXI channel names so the wrapper binds them one-to-one.
interface my_mult_axil_slave_if #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
);
  logic [ADDR_W-1:0]   AWADDR;
  logic [2:0]          AWPROT;
  logic                AWVALID;
  logic                AWREADY;
  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WVALID;
  logic                WREADY;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;
  logic [ADDR_W-1:0]   ARADDR;
  logic [2:0]          ARPROT;
  logic                ARVALID;
  logic                ARREADY;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RVALID;
  logic                RREADY;

  modport master (
    output AWADDR, AWPROT, AWVALID, input AWREADY,
    output WDATA, WSTRB, WVALID, input WREADY,
    input BRESP, BVALID, output BREADY,
    output ARADDR, ARPROT, ARVALID, input ARREADY,
    input RDATA, RRESP, RVALID, output RREADY
  );

  modport slave (
    input AWADDR, AWPROT, AWVALID, output AWREADY,
    input WDATA, WSTRB, WVALID, output WREADY,
    output BRESP, BVALID, input BREADY,
    input ARADDR, ARPROT, ARVALID, output ARREADY,
    output RDATA, RRESP, RVALID, input RREADY
  );
endinterface

// File: rtl/my_mult_axil_slave.sv
// AXI4-Lite slave with a five-register map driving an unsigned shift-add
// multiplier (one multiplier bit per cycle, LSB first, 2*DW-bit result).
module my_mult_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
) (
  input  logic                ACLK,
  input  logic                ARESET,
  my_mult_axil_slave_if.slave s00_axi,
  output logic                IRQ
);

  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned AW = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned IW = AW - 2;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(DW) + 1;

  localparam logic [IW-1:0] IDX_OP_A   = IW'(0);
  localparam logic [IW-1:0] IDX_OP_B   = IW'(1);
  localparam logic [IW-1:0] IDX_CTRL   = IW'(2);
  localparam logic [IW-1:0] IDX_RES_LO = IW'(3);
  localparam logic [IW-1:0] IDX_RES_HI = IW'(4);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t state;
  state_t state_next;

  // Bus-side registers
  logic          aw_ready;
  logic          ar_ready;
  logic          b_valid;
  logic [1:0]    b_resp;
  logic          r_valid;
  logic [1:0]    r_resp;
  logic [DW-1:0] r_data;

  // Register map
  logic [DW-1:0]   op_a;
  logic [DW-1:0]   op_b;
  logic [2*DW-1:0] result;
  logic            ie;
  logic            done;
  logic            busy;

  // Multiplier datapath
  logic [2*DW-1:0] mcand;
  logic [DW-1:0]   mplier;
  logic [2*DW-1:0] acc;
  logic [2*DW-1:0] acc_next;
  logic [CW-1:0]   bit_cnt;

  // Decode
  logic          wr_fire;
  logic          rd_fire;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic          ctrl_wr;
  logic          start_go;
  logic          finish;
  logic [DW-1:0] rd_mux_data;
  logic [1:0]    rd_mux_resp;
  logic          unused_bits;

  function automatic logic [DW-1:0] merge_strb(input logic [DW-1:0] cur,
                                               input logic [DW-1:0] wdat,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = cur;
    for (int unsigned i = 0; i < SW; i++) begin
      if (strb[i]) r[i*8 +: 8] = wdat[i*8 +: 8];
    end
    return r;
  endfunction

  // Address decode and handshake qualifiers
  always_comb begin
    wr_fire     = aw_ready & s00_axi.AWVALID & s00_axi.WVALID;
    rd_fire     = ar_ready & s00_axi.ARVALID;
    wr_idx      = s00_axi.AWADDR[AW-1:2];
    rd_idx      = s00_axi.ARADDR[AW-1:2];
    busy        = (state == S_RUN);
    ctrl_wr     = wr_fire & (wr_idx == IDX_CTRL) & s00_axi.WSTRB[0];
    start_go    = ctrl_wr & s00_axi.WDATA[0] & (state == S_IDLE);
    finish      = (state == S_RUN) & (bit_cnt == CW'(1));
    acc_next    = acc + (mplier[0] ? mcand : '0);
    unused_bits = ^{s00_axi.AWPROT, s00_axi.ARPROT,
                    s00_axi.AWADDR[1:0], s00_axi.ARADDR[1:0]};
  end

  // Read-data mux sampled on the read handshake edge
  always_comb begin
    rd_mux_data = '0;
    rd_mux_resp = RESP_OKAY;
    case (rd_idx)
      IDX_OP_A:   rd_mux_data = op_a;
      IDX_OP_B:   rd_mux_data = op_b;
      IDX_CTRL:   rd_mux_data = {{(DW-3){1'b0}}, ie, done, busy};
      IDX_RES_LO: rd_mux_data = result[DW-1:0];
      IDX_RES_HI: rd_mux_data = result[2*DW-1:DW];
      default:    rd_mux_resp = RESP_SLVERR;
    endcase
  end

  // Write channel: single-cycle ready pulse, response held until accepted
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_ready <= 1'b0;
      b_valid  <= 1'b0;
      b_resp   <= RESP_OKAY;
    end else begin
      aw_ready <= ~aw_ready & s00_axi.AWVALID & s00_axi.WVALID & ~b_valid;
      if (wr_fire) begin
        b_valid <= 1'b1;
        b_resp  <= (wr_idx > IDX_RES_HI) ? RESP_SLVERR : RESP_OKAY;
      end else if (b_valid && s00_axi.BREADY) begin
        b_valid <= 1'b0;
      end
    end
  end

  // Read channel: data captured with the address handshake, held until accepted
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_resp   <= RESP_OKAY;
      r_data   <= '0;
    end else begin
      ar_ready <= ~ar_ready & s00_axi.ARVALID & ~r_valid;
      if (rd_fire) begin
        r_valid <= 1'b1;
        r_data  <= rd_mux_data;
        r_resp  <= rd_mux_resp;
      end else if (r_valid && s00_axi.RREADY) begin
        r_valid <= 1'b0;
      end
    end
  end

  // Control FSM state register
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= S_IDLE;
    else        state <= state_next;
  end

  // Control FSM next state
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start_go) state_next = S_RUN;
      S_RUN:   if (finish)   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Register file and shift-add datapath; a completion in the same edge as a
  // DONE-clear wins because its assignment comes later in the block.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      op_a    <= '0;
      op_b    <= '0;
      result  <= '0;
      ie      <= 1'b0;
      done    <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      bit_cnt <= '0;
    end else begin
      if (wr_fire && wr_idx == IDX_OP_A)
        op_a <= merge_strb(op_a, s00_axi.WDATA, s00_axi.WSTRB);
      if (wr_fire && wr_idx == IDX_OP_B)
        op_b <= merge_strb(op_b, s00_axi.WDATA, s00_axi.WSTRB);
      if (ctrl_wr) begin
        ie <= s00_axi.WDATA[2];
        if (s00_axi.WDATA[1]) done <= 1'b0;
      end
      if (start_go) begin
        mcand   <= {{DW{1'b0}}, op_a};
        mplier  <= op_b;
        acc     <= '0;
        bit_cnt <= CW'(DW);
        done    <= 1'b0;
      end else if (state == S_RUN) begin
        acc     <= acc_next;
        mcand   <= mcand << 1;
        mplier  <= mplier >> 1;
        bit_cnt <= bit_cnt - CW'(1);
        if (finish) begin
          result <= acc_next;
          done   <= 1'b1;
        end
      end
    end
  end

  // Bus outputs and level interrupt
  always_comb begin
    s00_axi.AWREADY = aw_ready;
    s00_axi.WREADY  = aw_ready;
    s00_axi.BVALID  = b_valid;
    s00_axi.BRESP   = b_resp;
    s00_axi.ARREADY = ar_ready;
    s00_axi.RVALID  = r_valid;
    s00_axi.RDATA   = r_data;
    s00_axi.RRESP   = r_resp;
    IRQ             = done & ie;
  end

endmodule

// File: tb/tb_my_mult_axil_slave.sv
// Bench for my_mult_axil_slave: directed literal checks plus randomized traffic,
// all continuously compared against a transaction-level model of the register map.
module tb_my_mult_axil_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic irq;

  always #5 clk = ~clk;

  my_mult_axil_slave_if #(.ADDR_W(5), .DATA_W(32)) bus ();

  my_mult_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5)
  ) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .s00_axi(bus),
    .IRQ    (irq)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endfunction

  // ---------------- behavioural model ----------------
  logic [31:0] m_a, m_b, m_lo, m_hi;
  logic [63:0] m_prod;
  logic        m_ie, m_done, m_busy;
  longint unsigned edge_no = 0;
  longint unsigned m_done_edge = 0;
  logic [31:0] rq_data[$];
  logic [1:0]  rq_resp[$];
  logic [1:0]  bq[$];
  logic        exp_awready, exp_arready;
  bit          started = 0;

  function automatic logic [31:0] merge(input logic [31:0] cur, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic void model_read(input logic [2:0] idx, output logic [31:0] d, output logic [1:0] r);
    d = '0;
    r = 2'b00;
    case (idx)
      3'd0: d = m_a;
      3'd1: d = m_b;
      3'd2: d = {29'b0, m_ie, m_done, m_busy};
      3'd3: d = m_lo;
      3'd4: d = m_hi;
      default: r = 2'b10;
    endcase
  endfunction

  // Compare the visible outputs, then advance the model across the coming edge.
  always @(negedge clk) begin
    logic [31:0] rd;
    logic [1:0]  rr;
    logic [2:0]  wi;
    logic        fin, busy_pre, wr_hs, rd_hs, aw_nx, ar_nx;
    edge_no++;
    if (started) begin
      check("irq", irq, m_done & m_ie);
      check("awready", bus.AWREADY, exp_awready);
      check("wready", bus.WREADY, exp_awready);
      check("arready", bus.ARREADY, exp_arready);
      check("bvalid", bus.BVALID, bq.size() != 0);
      if (bq.size() != 0) check("bresp", bus.BRESP, bq[0]);
      check("rvalid", bus.RVALID, rq_data.size() != 0);
      if (rq_data.size() != 0) begin
        check("rdata", bus.RDATA, rq_data[0]);
        check("rresp", bus.RRESP, rq_resp[0]);
      end
    end
    if (rst) begin
      started = 1;
      m_a = '0; m_b = '0; m_lo = '0; m_hi = '0; m_prod = '0;
      m_ie = 0; m_done = 0; m_busy = 0;
      rq_data.delete(); rq_resp.delete(); bq.delete();
      exp_awready = 0; exp_arready = 0;
    end else if (started) begin
      wr_hs = exp_awready & bus.AWVALID & bus.WVALID;
      rd_hs = exp_arready & bus.ARVALID;
      aw_nx = !exp_awready & bus.AWVALID & bus.WVALID & (bq.size() == 0);
      ar_nx = !exp_arready & bus.ARVALID & (rq_data.size() == 0);
      if (rq_data.size() != 0 && bus.RREADY) begin
        void'(rq_data.pop_front());
        void'(rq_resp.pop_front());
      end
      if (bq.size() != 0 && bus.BREADY) void'(bq.pop_front());
      if (rd_hs) begin
        model_read(bus.ARADDR[4:2], rd, rr);
        rq_data.push_back(rd);
        rq_resp.push_back(rr);
      end
      busy_pre = m_busy;
      fin = m_busy && (edge_no == m_done_edge);
      if (wr_hs) begin
        wi = bus.AWADDR[4:2];
        bq.push_back(wi > 3'd4 ? 2'b10 : 2'b00);
        if (wi == 3'd0) m_a = merge(m_a, bus.WDATA, bus.WSTRB);
        if (wi == 3'd1) m_b = merge(m_b, bus.WDATA, bus.WSTRB);
        if (wi == 3'd2 && bus.WSTRB[0]) begin
          m_ie = bus.WDATA[2];
          if (bus.WDATA[1]) m_done = 0;
          if (bus.WDATA[0] && !busy_pre) begin
            m_busy = 1;
            m_done = 0;
            m_prod = {32'b0, m_a} * {32'b0, m_b};
            m_done_edge = edge_no + 32;
          end
        end
      end
      if (fin) begin
        m_busy = 0;
        m_done = 1;
        {m_hi, m_lo} = m_prod;
      end
      exp_awready = aw_nx;
      exp_arready = ar_nx;
    end
  end

  // ---------------- bus tasks ----------------
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int unsigned dly, output logic [1:0] resp);
    int unsigned n;
    @(posedge clk); #1;
    bus.AWADDR = a; bus.AWPROT = 3'($urandom); bus.AWVALID = 1;
    bus.WDATA = d; bus.WSTRB = s; bus.WVALID = 1; bus.BREADY = 0;
    n = 0;
    while (bus.AWREADY !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) fail_timeout("aw_wait");
    @(posedge clk); #1;
    bus.AWVALID = 0; bus.WVALID = 0;
    n = 0;
    while (bus.BVALID !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) fail_timeout("b_wait");
    repeat (dly) begin @(posedge clk); #1; end
    resp = bus.BRESP;
    bus.BREADY = 1;
    @(posedge clk); #1;
    bus.BREADY = 0;
  endtask

  task automatic axi_read(input logic [4:0] a, input int unsigned dly,
                          output logic [31:0] d, output logic [1:0] resp);
    int unsigned n;
    @(posedge clk); #1;
    bus.ARADDR = a; bus.ARPROT = 3'($urandom); bus.ARVALID = 1; bus.RREADY = 0;
    n = 0;
    while (bus.ARREADY !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) fail_timeout("ar_wait");
    @(posedge clk); #1;
    bus.ARVALID = 0;
    n = 0;
    while (bus.RVALID !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) fail_timeout("r_wait");
    repeat (dly) begin @(posedge clk); #1; end
    d = bus.RDATA;
    resp = bus.RRESP;
    bus.RREADY = 1;
    @(posedge clk); #1;
    bus.RREADY = 0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d, input string name);
    logic [1:0] r;
    axi_write(a, d, 4'hF, 0, r);
    check(name, r, 2'b00);
  endtask

  task automatic rd_expect(input logic [4:0] a, input logic [31:0] exp, input string name);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(a, 0, d, r);
    check(name, d, exp);
  endtask

  task automatic wait_done();
    logic [31:0] d;
    logic [1:0]  r;
    int unsigned n;
    n = 0;
    do begin
      axi_read(5'h08, 0, d, r);
      n++;
    end while (d[1] !== 1'b1 && n < 40);
    if (d[1] !== 1'b1) fail_timeout("wait_done");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d, d2;
    logic [1:0]  r, r2;
    logic [4:0]  a;
    int unsigned k;

    bus.AWADDR = '0; bus.AWPROT = '0; bus.AWVALID = 0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WVALID = 0; bus.BREADY = 0;
    bus.ARADDR = '0; bus.ARPROT = '0; bus.ARVALID = 0; bus.RREADY = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("irq_reset", irq, 1'b0);
    rd_expect(5'h08, 32'h0, "status_reset");
    rd_expect(5'h0C, 32'h0, "res_lo_reset");

    // 3 x 5
    wr(5'h00, 32'd3, "bresp_op_a");
    wr(5'h04, 32'd5, "bresp_op_b");
    wr(5'h08, 32'h1, "bresp_start");
    rd_expect(5'h08, 32'h1, "status_busy");
    wait_done();
    rd_expect(5'h08, 32'h2, "status_done");
    rd_expect(5'h0C, 32'h0000000F, "res_lo_3x5");
    rd_expect(5'h10, 32'h0, "res_hi_3x5");

    // max x max, then zero operand
    wr(5'h00, 32'hFFFFFFFF, "bresp_a_max");
    wr(5'h04, 32'hFFFFFFFF, "bresp_b_max");
    wr(5'h08, 32'h1, "bresp_start_max");
    wait_done();
    rd_expect(5'h10, 32'hFFFFFFFE, "res_hi_max");
    rd_expect(5'h0C, 32'h00000001, "res_lo_max");
    wr(5'h00, 32'h0, "bresp_a_zero");
    wr(5'h04, 32'h12345678, "bresp_b_zero");
    wr(5'h08, 32'h1, "bresp_start_zero");
    wait_done();
    rd_expect(5'h0C, 32'h0, "res_lo_zero");
    rd_expect(5'h10, 32'h0, "res_hi_zero");

    // byte strobes and unmapped offsets
    axi_write(5'h00, 32'hAABBCCDD, 4'b0101, 0, r);
    rd_expect(5'h00, 32'h00BB00DD, "op_a_strb");
    axi_write(5'h14, 32'h1234, 4'hF, 0, r);
    check("bresp_unmapped", r, 2'b10);
    axi_read(5'h18, 0, d, r);
    check("rdata_unmapped", d, 32'h0);
    check("rresp_unmapped", r, 2'b10);

    // operand rewrite and ignored START while busy
    wr(5'h00, 32'd2, "bresp_a2");
    wr(5'h04, 32'd3, "bresp_b3");
    wr(5'h08, 32'h1, "bresp_start_2x3");
    wr(5'h00, 32'd7, "bresp_a7_busy");
    wr(5'h08, 32'h1, "bresp_start_busy");
    wait_done();
    rd_expect(5'h0C, 32'd6, "res_2x3");
    wr(5'h08, 32'h1, "bresp_start_7x3");
    wait_done();
    rd_expect(5'h0C, 32'd21, "res_7x3");

    // interrupt enable and DONE clear
    wr(5'h08, 32'h4, "bresp_ie");
    wr(5'h00, 32'd4, "bresp_a4");
    wr(5'h04, 32'd4, "bresp_b4");
    wr(5'h08, 32'h5, "bresp_start_ie");
    wait_done();
    check("irq_done", irq, 1'b1);
    rd_expect(5'h0C, 32'd16, "res_4x4");
    wr(5'h08, 32'h6, "bresp_clear");
    rd_expect(5'h08, 32'h4, "status_cleared");
    check("irq_cleared", irq, 1'b0);

    // stalled responses on both channels at once
    fork
      axi_write(5'h04, 32'h0000ABCD, 4'hF, 10, r);
      axi_read(5'h0C, 10, d, r2);
    join
    check("bresp_stall", r, 2'b00);
    check("rdata_stall", d, 32'd16);
    check("rresp_stall", r2, 2'b00);

    // reset in the middle of a multiply
    wr(5'h00, 32'd9, "bresp_a9");
    wr(5'h08, 32'h1, "bresp_start_rst");
    repeat (6) @(posedge clk);
    #1 rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    rd_expect(5'h08, 32'h0, "status_after_rst");
    rd_expect(5'h0C, 32'h0, "res_lo_after_rst");
    rd_expect(5'h10, 32'h0, "res_hi_after_rst");
    rd_expect(5'h00, 32'h0, "op_a_after_rst");

    // randomized traffic, judged by the model
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 9);
      if (k < 4) a = 5'($urandom_range(0, 2) * 4 + $urandom_range(0, 3));
      else       a = 5'($urandom_range(0, 31));
      if (k < 5) begin
        if (a[4:2] == 3'd2) d = 32'($urandom_range(0, 7));
        else                d = $urandom;
        axi_write(a, d, 4'($urandom), $urandom_range(0, 3), r);
      end else if (k < 8) begin
        axi_read(a, $urandom_range(0, 3), d, r);
      end else begin
        fork
          axi_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), r);
          axi_read(5'($urandom_range(0, 31)), $urandom_range(0, 3), d2, r2);
        join
      end
      repeat ($urandom_range(0, 4)) @(posedge clk);
    end

    repeat (40) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
